// File: rtl/dac_serial_multicanal.sv
// Multi-channel serial DAC driver: one SYNC-framed {cmd,addr,data} word per channel, then one LDAC pulse. Optional `DAC_OFFSET_BINAIRE_EN`.
// Latency: accept edge to LDAC fall = 1 + NB_CH*(1 + (8+DATA_W)*CLK_DIV + SYNC_GAP) clk_in cycles.
// Backpressure: pret low while busy; strobes arriving then are dropped and flagged once on debordement.
module dac_serial_multicanal #(
  parameter int         NB_CH     = 2,
  parameter int         DATA_W    = 16,
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] CMD_WRITE = 4'h3,
  parameter int         SYNC_GAP  = 2,
  parameter int         LDAC_W    = 2
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [NB_CH*DATA_W-1:0] audio_in,
  input  logic                    nv_echantillon,
  output logic                    pret,
  output logic                    debordement,
  output logic                    SCLK,
  output logic                    sync,
  output logic                    audio_out,
  output logic                    LDAC
);

  localparam int FRAME_W = 8 + DATA_W;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int GAP_W   = $clog2(SYNC_GAP + 1);
  localparam int LD_W    = $clog2(LDAC_W + 1);

  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV/2 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);
  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(LDAC_W - 1);
  localparam logic [3:0]       CH_LAST  = 4'(NB_CH - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_LOAD_DAC = 3'd4;

  logic [2:0]              state;
  logic [3:0]              ch_cnt;
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  logic [LD_W-1:0]         ld_cnt;
  logic [FRAME_W-2:0]      shreg;
  logic [NB_CH*DATA_W-1:0] samples;
  logic [DATA_W-1:0]       cur_sample;
  logic [FRAME_W-1:0]      cur_frame;
  logic                    nv_d;
  logic                    accept;

  function automatic logic [DATA_W-1:0] to_dac(input logic [DATA_W-1:0] s);
`ifdef DAC_OFFSET_BINAIRE_EN
    return {~s[DATA_W-1], s[DATA_W-2:0]};
`else
    return s;
`endif
  endfunction

  assign accept = nv_echantillon && pret && (state == ST_IDLE);

  always_comb begin
    cur_sample = samples[int'(ch_cnt)*DATA_W +: DATA_W];
    cur_frame  = {CMD_WRITE, ch_cnt, cur_sample};
  end

  // Samples are frozen on acceptance; later strobes never touch them.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      samples <= '0;
    end else if (accept) begin
      for (int k = 0; k < NB_CH; k++) begin
        samples[k*DATA_W +: DATA_W] <= to_dac(audio_in[k*DATA_W +: DATA_W]);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      nv_d        <= 1'b0;
      debordement <= 1'b0;
    end else begin
      nv_d        <= nv_echantillon;
      debordement <= nv_echantillon && !nv_d && !pret;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pret      <= 1'b1;
      SCLK      <= 1'b1;
      sync      <= 1'b1;
      audio_out <= 1'b0;
      LDAC      <= 1'b1;
      ch_cnt    <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ld_cnt    <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pret   <= 1'b0;
            ch_cnt <= '0;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shreg     <= cur_frame[FRAME_W-2:0];
          audio_out <= cur_frame[FRAME_W-1];
          sync      <= 1'b0;
          SCLK      <= 1'b1;
          div_cnt   <= '0;
          bit_cnt   <= '0;
          state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_HALF) begin
            SCLK <= 1'b0;
          end
          // Data only moves on the rising SCLK edge so it is stable at the DAC's falling-edge sample.
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SCLK    <= 1'b1;
            if (bit_cnt == BIT_LAST) begin
              sync      <= 1'b1;
              audio_out <= 1'b0;
              gap_cnt   <= '0;
              state     <= ST_GAP;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              audio_out <= shreg[FRAME_W-2];
              shreg     <= {shreg[FRAME_W-3:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (ch_cnt == CH_LAST) begin
              ld_cnt <= '0;
              state  <= ST_LOAD_DAC;
            end else begin
              ch_cnt <= ch_cnt + 1'b1;
              state  <= ST_LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_LOAD_DAC: begin
          if (LDAC) begin
            LDAC <= 1'b0;
          end else if (ld_cnt == LD_LAST) begin
            LDAC  <= 1'b1;
            pret  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
